// File: rtl/if_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_bridge
// Brief   : Fetch-side responder for the PC register. Turns each ce/pc
//           request into one single-beat read on a req/gnt/rvalid bus and
//           returns inst/inst_pc/inst_err to the IF/ID boundary.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_bridge #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                kill_q;
  logic                inst_valid_q;
  logic [DATA_W-1:0]   inst_q;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic                inst_err_q;

  logic                accept_w;
  logic                misalign_w;

  assign accept_w   = ce && !flush && (pc[1:0] == 2'b00);
  assign misalign_w = ce && !flush && (pc[1:0] != 2'b00);

  // Bus request is decoded from state so an async reset drops it immediately.
  always_comb begin
    mem_req  = (state_q == REQ);
    mem_addr = (state_q == REQ) ? addr_q : '0;
  end

  // Stall holds the PC until the response cycle of the current fetch.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    stall = accept_w;
        REQ:     stall = 1'b1;
        WAIT:    stall = !mem_rvalid;
        DRAIN:   stall = !mem_rvalid;
        default: stall = 1'b0;
      endcase
    end
  end

  // Fetch FSM with registered IF/ID outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= RESET_INST;
      inst_pc_q    <= '0;
      inst_err_q   <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (accept_w) begin
            addr_q  <= pc;
            state_q <= REQ;
          end else if (misalign_w) begin
            // Misaligned PC faults locally without touching the bus.
            inst_valid_q <= 1'b1;
            inst_err_q   <= 1'b1;
            inst_q       <= '0;
            inst_pc_q    <= pc;
          end
        end
        REQ: begin
          if (flush) kill_q <= 1'b1;
          // The request is held until granted; a flush only marks it dead.
          if (mem_gnt) state_q <= (kill_q || flush) ? DRAIN : WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (!flush) begin
              inst_valid_q <= 1'b1;
              inst_q       <= mem_rdata;
              inst_pc_q    <= addr_q;
              inst_err_q   <= mem_err;
            end
            kill_q  <= 1'b0;
            state_q <= IDLE;
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Response of a killed fetch is consumed and thrown away.
          if (mem_rvalid) begin
            kill_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_err   = inst_err_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_bridge
// Brief   : Directed self-checking bench for if_fetch_bridge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_fetch_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              ce;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_err;

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch_bridge #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RESET_INST(32'h0)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pc        (pc),
    .flush     (flush),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_err  (inst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed 2 ns after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus(input logic g, input logic rv, input logic [31:0] d, input logic e);
    mem_gnt    = g;
    mem_rvalid = rv;
    mem_rdata  = d;
    mem_err    = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ce = 1'b1; pc = '0; flush = 1'b0;
    bus(1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    #1;
    // Reset state
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_err", inst_err, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0; ce = 1'b0;
    tick();

    // ---- Zero-wait fetch at 0x0 ----
    ce = 1'b1; pc = 32'h0; #1;
    chk("zw_accept_stall", stall, 1);
    chk("zw_accept_noreq", mem_req, 0);
    tick();
    ce = 1'b0; bus(1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("zw_req", mem_req, 1);
    chk("zw_addr", mem_addr, 32'h0);
    chk("zw_req_stall", stall, 1);
    tick();
    bus(1'b0, 1'b1, 32'h24020005, 1'b0); #1;
    chk("zw_rv_stall", stall, 0);
    chk("zw_rv_noreq", mem_req, 0);
    chk("zw_rv_novalid", inst_valid, 0);
    tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("zw_valid", inst_valid, 1);
    chk("zw_inst", inst, 32'h24020005);
    chk("zw_pc", inst_pc, 32'h0);
    chk("zw_err", inst_err, 0);
    tick(); #1;
    chk("zw_pulse_end", inst_valid, 0);
    chk("zw_inst_hold", inst, 32'h24020005);

    // ---- Wait states at 0x40 ----
    ce = 1'b1; pc = 32'h40; tick();
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus((i == 3), 1'b0, 32'h0, 1'b0); #1;
      chk("ws_req", mem_req, 1);
      chk("ws_addr", mem_addr, 32'h40);
      chk("ws_stall", stall, 1);
      tick();
    end
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("ws_wait_stall", stall, 1);
    chk("ws_wait_noreq", mem_req, 0);
    tick();
    bus(1'b0, 1'b1, 32'h11112222, 1'b0); #1;
    chk("ws_rv_stall", stall, 0);
    tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("ws_valid", inst_valid, 1);
    chk("ws_inst", inst, 32'h11112222);
    chk("ws_pc", inst_pc, 32'h40);
    tick(); #1;
    chk("ws_single", inst_valid, 0);

    // ---- Flush in WAIT at 0x80, then fetch at 0x84 ----
    ce = 1'b1; pc = 32'h80; tick();
    ce = 1'b0; bus(1'b1, 1'b0, 32'h0, 1'b0); tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); flush = 1'b1; #1;
    chk("fw_flush_stall", stall, 1);
    tick();
    flush = 1'b0; bus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0); #1;
    chk("fw_drain_stall", stall, 0);
    tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("fw_novalid", inst_valid, 0);
    chk("fw_inst_kept", inst, 32'h11112222);
    ce = 1'b1; pc = 32'h84; tick();
    ce = 1'b0; bus(1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("fw_next_addr", mem_addr, 32'h84);
    tick();
    bus(1'b0, 1'b1, 32'h33334444, 1'b0); tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("fw_next_valid", inst_valid, 1);
    chk("fw_next_inst", inst, 32'h33334444);
    chk("fw_next_pc", inst_pc, 32'h84);

    // ---- Flush in REQ before grant at 0xC0 ----
    ce = 1'b1; pc = 32'hC0; tick();
    ce = 1'b0; flush = 1'b1; #1;
    chk("fr_req_flush", mem_req, 1);
    tick();
    flush = 1'b0; #1;
    chk("fr_req_held", mem_req, 1);
    chk("fr_addr_held", mem_addr, 32'hC0);
    tick();
    bus(1'b1, 1'b0, 32'h0, 1'b0); #1;
    chk("fr_req_gnt", mem_req, 1);
    tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("fr_drain_stall", stall, 1);
    chk("fr_drain_noreq", mem_req, 0);
    tick();
    bus(1'b0, 1'b1, 32'h99999999, 1'b0); #1;
    chk("fr_rv_stall", stall, 0);
    tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("fr_novalid", inst_valid, 0);
    chk("fr_inst_kept", inst, 32'h33334444);

    // ---- Misaligned PC fault ----
    ce = 1'b1; pc = 32'h2; #1;
    chk("ma_stall", stall, 0);
    chk("ma_noreq", mem_req, 0);
    tick();
    ce = 1'b0; #1;
    chk("ma_noreq2", mem_req, 0);
    chk("ma_valid", inst_valid, 1);
    chk("ma_err", inst_err, 1);
    chk("ma_pc", inst_pc, 32'h2);
    chk("ma_inst", inst, 32'h0);
    tick();

    // ---- Bus error at 0x100 ----
    ce = 1'b1; pc = 32'h100; tick();
    ce = 1'b0; bus(1'b1, 1'b0, 32'h0, 1'b0); tick();
    bus(1'b0, 1'b1, 32'h00000055, 1'b1); tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("be_valid", inst_valid, 1);
    chk("be_err", inst_err, 1);
    chk("be_pc", inst_pc, 32'h100);
    chk("be_inst", inst, 32'h55);
    tick();

    // ---- Async reset in REQ drops mem_req immediately ----
    ce = 1'b1; pc = 32'h300; tick();
    ce = 1'b0; #1;
    chk("rr_req", mem_req, 1);
    rst = 1'b1; #1;
    chk("rr_req_drop", mem_req, 0);
    chk("rr_stall", stall, 0);
    tick();
    rst = 1'b0; tick();

    // ---- Reset in WAIT, late response ignored ----
    ce = 1'b1; pc = 32'h200; tick();
    ce = 1'b0; bus(1'b1, 1'b0, 32'h0, 1'b0); tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("rw_wait_stall", stall, 1);
    rst = 1'b1; #1;
    chk("rw_rst_noreq", mem_req, 0);
    chk("rw_rst_stall", stall, 0);
    tick();
    rst = 1'b0; tick();
    bus(1'b0, 1'b1, 32'hCAFEF00D, 1'b0); #1;
    chk("rw_late_stall", stall, 0);
    tick();
    bus(1'b0, 1'b0, 32'h0, 1'b0); #1;
    chk("rw_late_novalid", inst_valid, 0);
    chk("rw_late_inst", inst, 32'h0);
    chk("rw_late_noreq", mem_req, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
